// File: rtl/bus_slave_pkg.sv
// Shared types and default geometry for the bit-serial burst memory slave.
package bus_slave_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 8;
  localparam int BURST_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_RD_FETCH,
    ST_TX
  } state_e;

endpackage

// File: rtl/bus_slave_mem.sv
// Single-port RAM, synchronous read with one cycle of latency, write-first on a same-cycle write.
module bus_slave_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
      rdata_q     <= wdata;
    end else begin
      rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_slave_burst_mem.sv
// Bit-serial bus slave: deserialises address/burst/write data, serialises read data, incrementing bursts.
//
// state       | meaning
// ST_IDLE     | waiting for exactly one of read_en/write_en; first address bit may be taken
// ST_RX_ADDR  | shifting in address (and burst length on the first BURST_W bits)
// ST_RX_DATA  | shifting in a write word; commit on its last bit
// ST_RD_FETCH | one-cycle wait for the RAM read; loads the tx shift register
// ST_TX       | shifting out the read word while master_ready is high
module bus_slave_burst_mem
  import bus_slave_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_address,
  input  logic rx_burst,
  input  logic rx_data,
  output logic slave_ready,
  output logic slave_valid,
  output logic tx_data,
  output logic rx_done,
  output logic slave_tx_done,
  output logic busy
);

  localparam int CNT_W  = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  localparam int BEAT_W = BURST_W + 1;

  state_e              state_q, state_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic                slave_ready_q, slave_valid_q, rx_done_q, tx_done_q, busy_q;
  logic                rx_done_d, tx_done_d;

  logic                start, abort, rx_acc, tx_acc, addr_phase, last_beat;
  logic [DATA_W-1:0]   rx_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rdata;

  always_comb begin
    start      = read_en ^ write_en;
    abort      = op_wr_q ? (!write_en || read_en) : (!read_en || write_en);
    rx_acc     = master_valid & slave_ready_q;
    tx_acc     = master_ready & slave_valid_q;
    rx_word    = {rx_sr_q[DATA_W-2:0], rx_data};
    last_beat  = (beat_q == {1'b0, burst_q});
    addr_phase = 1'b0;

    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    rx_done_d = 1'b0;
    tx_done_d = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_wr_d    = write_en;
          state_d    = ST_RX_ADDR;
          addr_phase = 1'b1;
        end
      end
      ST_RX_ADDR: begin
        if (abort) state_d = ST_IDLE;
        else       addr_phase = 1'b1;
      end
      ST_RX_DATA: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rx_acc) begin
          rx_sr_d = rx_word;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            mem_we    = 1'b1;
            rx_done_d = 1'b1;
            addr_d    = addr_q + 1'b1;
            bit_cnt_d = '0;
            beat_d    = beat_q + 1'b1;
            if (last_beat) state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_RD_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          tx_sr_d = mem_rdata;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tx_acc) begin
          tx_sr_d = tx_sr_q << 1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            addr_d    = addr_q + 1'b1;
            bit_cnt_d = '0;
            beat_d    = beat_q + 1'b1;
            if (last_beat) begin
              tx_done_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              state_d   = ST_RD_FETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address phase is shared by IDLE (first bit may ride on the start cycle) and RX_ADDR.
    if (addr_phase && rx_acc) begin
      addr_d = {addr_q[ADDR_W-2:0], rx_address};
      if (bit_cnt_q < CNT_W'(BURST_W)) burst_d = {burst_q[BURST_W-2:0], rx_burst};
      if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
        bit_cnt_d = '0;
        state_d   = op_wr_d ? ST_RX_DATA : ST_RD_FETCH;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // Any return to IDLE (completion or abort) discards partial words and clears counters.
    if (state_d == ST_IDLE) begin
      bit_cnt_d = '0;
      beat_d    = '0;
      tx_sr_d   = '0;
    end
  end

  // Reads track the next address so the word is ready by the RD_FETCH cycle.
  assign mem_addr = mem_we ? addr_q : addr_d;

  bus_slave_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (rx_word),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_wr_q       <= 1'b0;
      addr_q        <= '0;
      burst_q       <= '0;
      beat_q        <= '0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
      rx_done_q     <= 1'b0;
      tx_done_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_wr_q       <= op_wr_d;
      addr_q        <= addr_d;
      burst_q       <= burst_d;
      beat_q        <= beat_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      slave_ready_q <= (state_d == ST_IDLE) || (state_d == ST_RX_ADDR) || (state_d == ST_RX_DATA);
      slave_valid_q <= (state_d == ST_TX);
      rx_done_q     <= rx_done_d;
      tx_done_q     <= tx_done_d;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign slave_ready   = slave_ready_q;
  assign slave_valid   = slave_valid_q;
  assign tx_data       = tx_sr_q[DATA_W-1];
  assign rx_done       = rx_done_q;
  assign slave_tx_done = tx_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_bus_slave_burst_mem.sv
// Directed plus randomized bench for bus_slave_burst_mem against an array-based memory model.
module tb_bus_slave_burst_mem;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk, reset;
  logic read_en, write_en, master_valid, master_ready;
  logic rx_address, rx_burst, rx_data;
  logic slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, busy;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wbuf [16];
  int vectors = 0;
  int miscompares = 0;
  int rx_done_cnt = 0;
  int tx_done_cnt = 0;

  bus_slave_burst_mem #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk           (clk),
    .reset         (reset),
    .read_en       (read_en),
    .write_en      (write_en),
    .master_valid  (master_valid),
    .master_ready  (master_ready),
    .rx_address    (rx_address),
    .rx_burst      (rx_burst),
    .rx_data       (rx_data),
    .slave_ready   (slave_ready),
    .slave_valid   (slave_valid),
    .tx_data       (tx_data),
    .rx_done       (rx_done),
    .slave_tx_done (slave_tx_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_done)       rx_done_cnt <= rx_done_cnt + 1;
    if (slave_tx_done) tx_done_cnt <= tx_done_cnt + 1;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic a, input logic b, input logic d, input bit gaps);
    bit acc = 1'b0;
    for (int g = 0; g < 40 && !acc; g++) begin
      master_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rx_address   = a;
      rx_burst     = b;
      rx_data      = d;
      acc          = master_valid && slave_ready;
      cyc();
    end
    master_valid = 1'b0;
    chk("rx_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_addr(input logic [AW-1:0] a, input logic [BW-1:0] bl, input bit gaps);
    for (int i = 0; i < AW; i++)
      send_bit(a[AW-1-i], (i < BW) ? bl[BW-1-i] : 1'b0, 1'($urandom), gaps);
  endtask

  // Writes wbuf[0..bl] from address a; abort_beat >= 0 drops write_en after abort_bits of that beat.
  task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] bl, input bit gaps,
                          input int abort_beat, input int abort_bits);
    int rx0 = rx_done_cnt;
    read_en  = 1'b0;
    write_en = 1'b1;
    send_addr(a, bl, gaps);
    for (int b = 0; b <= int'(bl); b++) begin
      if (b == abort_beat) begin
        for (int j = 0; j < abort_bits; j++) send_bit(1'b0, 1'b0, wbuf[b][DW-1-j], gaps);
        write_en = 1'b0;
        cyc();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx_done_cnt", 32'(rx_done_cnt - rx0), 32'(b));
        return;
      end
      for (int j = 0; j < DW; j++) send_bit(1'b0, 1'b0, wbuf[b][DW-1-j], gaps);
      chk("rx_done_pulse", 32'(rx_done), 32'd1);
      ref_mem[(int'(a) + b) % DEPTH] = wbuf[b];
    end
    chk("write_end_busy", 32'(busy), 32'd0);
    write_en = 1'b0;
    cyc();
    chk("rx_done_cnt", 32'(rx_done_cnt - rx0), 32'(int'(bl) + 1));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [BW-1:0] bl, input bit gaps, input bit stall);
    int tx0 = tx_done_cnt;
    logic [7:0] exp;
    bit acc;
    write_en = 1'b0;
    read_en  = 1'b1;
    send_addr(a, bl, gaps);
    for (int b = 0; b <= int'(bl); b++) begin
      chk("fetch_valid", 32'(slave_valid), 32'd0);
      chk("fetch_ready", 32'(slave_ready), 32'd0);
      cyc();
      exp = ref_mem[(int'(a) + b) % DEPTH];
      for (int j = 0; j < DW; j++) begin
        acc = 1'b0;
        for (int g = 0; g < 40 && !acc; g++) begin
          master_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          chk("tx_valid", 32'(slave_valid), 32'd1);
          chk("tx_bit", 32'(tx_data), 32'(exp[DW-1-j]));
          acc = master_ready;
          cyc();
        end
        master_ready = 1'b0;
        chk("tx_accept", 32'(acc), 32'd1);
      end
    end
    chk("tx_done_pulse", 32'(slave_tx_done), 32'd1);
    chk("read_end_busy", 32'(busy), 32'd0);
    read_en = 1'b0;
    cyc();
    chk("tx_done_cnt", 32'(tx_done_cnt - tx0), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    reset = 1'b0; read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (2) cyc();
    chk("rst_slave_ready", 32'(slave_ready), 32'd1);
    chk("rst_slave_valid", 32'(slave_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_tx_done", 32'(slave_tx_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    cyc();

    // single-beat write/read
    wbuf[0] = 8'hA5;
    do_write(12'h123, 4'd0, 1'b0, -1, 0);
    do_read(12'h123, 4'd0, 1'b0, 1'b0);

    // burst wrapping past the top of memory
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(12'hFFE, 4'd3, 1'b0, -1, 0);
    chk("wrap_model_000", 32'(ref_mem[0]), 32'h33);
    do_read(12'hFFE, 4'd3, 1'b0, 1'b0);

    // stalls on tx and gaps on address
    do_read(12'hFFE, 4'd3, 1'b1, 1'b1);

    // abort during second beat
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'h0F; wbuf[3] = 8'hF0;
    do_write(12'h200, 4'd3, 1'b1, -1, 0);
    wbuf[0] = 8'h96; wbuf[1] = 8'h69; wbuf[2] = 8'hAA; wbuf[3] = 8'h55;
    do_write(12'h200, 4'd3, 1'b1, 1, 5);
    ref_mem[12'h200] = 8'h96;
    do_read(12'h200, 4'd3, 1'b0, 1'b1);

    // both enables high in IDLE
    read_en = 1'b1; write_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      master_valid = 1'b1; rx_address = 1'($urandom); rx_burst = 1'($urandom); rx_data = 1'($urandom);
      cyc();
      chk("both_en_busy", 32'(busy), 32'd0);
    end
    read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
    cyc();
    do_read(12'h123, 4'd0, 1'b0, 1'b0);

    // reset mid-TX
    read_en = 1'b1;
    send_addr(12'hFFF, 4'd1, 1'b0);
    cyc();
    master_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("midrst_slave_ready", 32'(slave_ready), 32'd1);
    chk("midrst_slave_valid", 32'(slave_valid), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_done", 32'(slave_tx_done), 32'd0);
    read_en = 1'b0; master_ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    do_read(12'hFFE, 4'd3, 1'b0, 1'b0);

    // randomized write/readback
    for (int t = 0; t < 16; t++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      rb = BW'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
      do_write(ra, rb, 1'b1, -1, 0);
      do_read(ra, BW'($urandom_range(0, int'(rb))), 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
